// File: rtl/id_stage_param.sv
// rtl/id_stage_param.sv - decode stage with register file, hazard detection and ID/EX register
//
// Purpose: decodes the ARM-subset instruction held in IF/ID, checks its
// condition against sr, reads operands from an internal 15-entry register
// file (r15 reads as pc), detects RAW / load-use hazards and registers the
// result into the ID/EX pipeline register.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   instruction, pc, sr           IF/ID instruction, pc (+4), status {N,Z,C,V}
//   wb_en_in, wb_dest, wb_value   write-back port into the register file
//   exe_wb_en, exe_mem_r_en,
//   exe_dest                      destination info of the instruction in EXE
//   mem_wb_en, mem_dest           destination info of the instruction in MEM
//   freeze, flush                 hold / bubble the ID/EX register
//   hazard                        combinational stall request to IF and IF/ID
//   wb_en .. src2_out             registered ID/EX outputs
module id_stage_param #(
    parameter int DATA_W     = 32,
    parameter bit FORWARD_EN = 1'b1,
    parameter bit LINK_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc,
    input  logic [3:0]        sr,
    input  logic              wb_en_in,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [3:0]        exe_dest,
    input  logic              mem_wb_en,
    input  logic [3:0]        mem_dest,
    input  logic              freeze,
    input  logic              flush,
    output logic              hazard,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic [DATA_W-1:0] pc_out,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [DATA_W-1:0] pc;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
    } idex_t;

    idex_t idex_q, idex_d;

    logic [DATA_W-1:0] rf_q [0:14];
    logic [DATA_W-1:0] rf_d [0:14];

    logic [1:0] mode;
    logic [3:0] op, cond;
    logic       s_bit, imm_bit;

    logic       dec_wb_en, dec_mem_r_en, dec_mem_w_en, dec_b, dec_s;
    logic [3:0] dec_cmd;
    logic       cond_pass;
    logic       n_f, z_f, c_f, v_f;

    logic [3:0] src1, src2;
    logic       src1_used, src2_used, is_str;
    logic       hz_exe, hz_mem;
    logic       link_we;

    logic [DATA_W-1:0] rd_rn, rd_rm;

    assign mode    = instruction[27:26];
    assign op      = instruction[24:21];
    assign s_bit   = instruction[20];
    assign imm_bit = instruction[25];
    assign cond    = instruction[31:28];
    assign {n_f, z_f, c_f, v_f} = sr;

    // Opcode decode; unknown mode-00 opcodes leave every control at 0.
    always_comb begin
        dec_wb_en    = 1'b0;
        dec_mem_r_en = 1'b0;
        dec_mem_w_en = 1'b0;
        dec_b        = 1'b0;
        dec_s        = 1'b0;
        dec_cmd      = 4'b0000;
        case (mode)
            2'b00: begin
                dec_wb_en = 1'b1;
                dec_s     = s_bit;
                case (op)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: begin dec_cmd = 4'b0100; dec_wb_en = 1'b0; end
                    4'b1000: begin dec_cmd = 4'b0110; dec_wb_en = 1'b0; end
                    default: begin dec_wb_en = 1'b0; dec_s = 1'b0; end
                endcase
            end
            2'b01: begin
                dec_cmd      = 4'b0010;
                dec_wb_en    = s_bit;
                dec_mem_r_en = s_bit;
                dec_mem_w_en = ~s_bit;
            end
            2'b10:   dec_b = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~c_f | z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = ~z_f & (n_f == v_f);
            4'b1101: cond_pass = z_f | (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // STR reads its store data through the second read port from the Rd field.
    assign is_str    = (mode == 2'b01) & ~s_bit;
    assign src1      = instruction[19:16];
    assign src2      = is_str ? instruction[15:12] : instruction[3:0];
    assign src1_used = ((mode == 2'b00) & (op != 4'b1101) & (op != 4'b1111)) | (mode == 2'b01);
    assign src2_used = is_str | ((mode == 2'b00) & ~imm_bit & ~instruction[4]);

    always_comb begin
        hz_exe = exe_wb_en & ((src1_used & (src1 == exe_dest)) | (src2_used & (src2 == exe_dest)));
        hz_mem = mem_wb_en & ((src1_used & (src1 == mem_dest)) | (src2_used & (src2 == mem_dest)));
        if (FORWARD_EN) begin
            hazard = exe_mem_r_en & hz_exe;
        end else begin
            hazard = hz_exe | hz_mem;
        end
    end

    // Reads: r15 is the pc; a same-cycle write-back is bypassed to the reader.
    always_comb begin
        if (src1 == 4'd15) begin
            rd_rn = pc;
        end else if (wb_en_in && wb_dest == src1) begin
            rd_rn = wb_value;
        end else begin
            rd_rn = rf_q[src1];
        end
        if (src2 == 4'd15) begin
            rd_rm = pc;
        end else if (wb_en_in && wb_dest == src2) begin
            rd_rm = wb_value;
        end else begin
            rd_rm = rf_q[src2];
        end
    end

    assign link_we = LINK_EN & cond_pass & (mode == 2'b10) & instruction[24]
                     & ~flush & ~freeze & ~hazard;

    // The link write is applied last so it wins over a write-back to r14.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wb_en_in && wb_dest != 4'd15) begin
            rf_d[wb_dest] = wb_value;
        end
        if (link_we) begin
            rf_d[14] = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= DATA_W'(i);
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // A hazard still loads the data fields; only the controls become a bubble.
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (!freeze) begin
            idex_d.val_rn        = rd_rn;
            idex_d.val_rm        = rd_rm;
            idex_d.pc            = pc;
            idex_d.imm           = imm_bit;
            idex_d.shift_operand = instruction[11:0];
            idex_d.signed_imm_24 = instruction[23:0];
            idex_d.dest          = instruction[15:12];
            idex_d.src1          = src1;
            idex_d.src2          = src2;
            if (cond_pass && !hazard) begin
                idex_d.wb_en    = dec_wb_en;
                idex_d.mem_r_en = dec_mem_r_en;
                idex_d.mem_w_en = dec_mem_w_en;
                idex_d.b        = dec_b;
                idex_d.s        = dec_s;
                idex_d.exe_cmd  = dec_cmd;
            end else begin
                idex_d.wb_en    = 1'b0;
                idex_d.mem_r_en = 1'b0;
                idex_d.mem_w_en = 1'b0;
                idex_d.b        = 1'b0;
                idex_d.s        = 1'b0;
                idex_d.exe_cmd  = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign wb_en         = idex_q.wb_en;
    assign mem_r_en      = idex_q.mem_r_en;
    assign mem_w_en      = idex_q.mem_w_en;
    assign b             = idex_q.b;
    assign s             = idex_q.s;
    assign exe_cmd       = idex_q.exe_cmd;
    assign val_rn        = idex_q.val_rn;
    assign val_rm        = idex_q.val_rm;
    assign pc_out        = idex_q.pc;
    assign imm           = idex_q.imm;
    assign shift_operand = idex_q.shift_operand;
    assign signed_imm_24 = idex_q.signed_imm_24;
    assign dest          = idex_q.dest;
    assign src1_out      = idex_q.src1;
    assign src2_out      = idex_q.src2;

endmodule

// File: tb/tb_id_stage_param.sv
// tb/tb_id_stage_param.sv - scoreboard bench for id_stage_param
module tb_id_stage_param;

    logic        clk, rst;
    logic [31:0] instruction, pc, wb_value;
    logic [3:0]  sr, wb_dest, exe_dest, mem_dest;
    logic        wb_en_in, exe_wb_en, exe_mem_r_en, mem_wb_en, freeze, flush;

    logic        hazard, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exe_cmd, dest, src1_out, src2_out;
    logic [31:0] val_rn, val_rm, pc_out;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    logic        n_hazard, n_wb_en, n_mem_r_en, n_mem_w_en, n_b, n_s, n_imm;
    logic [3:0]  n_exe_cmd, n_dest, n_src1_out, n_src2_out;
    logic [31:0] n_val_rn, n_val_rm, n_pc_out;
    logic [11:0] n_shift_operand;
    logic [23:0] n_signed_imm_24;

    id_stage_param #(.DATA_W(32), .FORWARD_EN(1'b1), .LINK_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .sr(sr),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .freeze(freeze), .flush(flush),
        .hazard(hazard), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .b(b), .s(s), .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm),
        .pc_out(pc_out), .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest(dest), .src1_out(src1_out),
        .src2_out(src2_out)
    );

    id_stage_param #(.DATA_W(32), .FORWARD_EN(1'b0), .LINK_EN(1'b1)) u_nofwd (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .sr(sr),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .freeze(freeze), .flush(flush),
        .hazard(n_hazard), .wb_en(n_wb_en), .mem_r_en(n_mem_r_en), .mem_w_en(n_mem_w_en),
        .b(n_b), .s(n_s), .exe_cmd(n_exe_cmd), .val_rn(n_val_rn), .val_rm(n_val_rm),
        .pc_out(n_pc_out), .imm(n_imm), .shift_operand(n_shift_operand),
        .signed_imm_24(n_signed_imm_24), .dest(n_dest), .src1_out(n_src1_out),
        .src2_out(n_src2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}
    typedef struct {
        string       name;
        logic [8:0]  ctrl;
        logic [3:0]  dest;
        logic        hz;
        logic        hz_nf;
        logic [31:0] vn;
        logic [31:0] vm;
        bit          chk_nf;
        bit          chk_vn;
        bit          chk_vm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [8:0] ctrl, input logic [3:0] d,
                                input logic hz, input logic hz_nf, input bit chk_nf,
                                input logic [31:0] vn, input bit chk_vn,
                                input logic [31:0] vm, input bit chk_vm);
        exp_t e;
        e.name = name; e.ctrl = ctrl; e.dest = d; e.hz = hz; e.hz_nf = hz_nf;
        e.chk_nf = chk_nf; e.vn = vn; e.chk_vn = chk_vn; e.vm = vm; e.chk_vm = chk_vm;
        return e;
    endfunction

    // Monitor: compares the registered outputs one half-cycle after the load edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                check({e.name, ".ctrl"}, 32'({wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}), 32'(e.ctrl));
                check({e.name, ".dest"}, 32'(dest), 32'(e.dest));
                check({e.name, ".hazard"}, 32'(hazard), 32'(e.hz));
                if (e.chk_nf) check({e.name, ".hazard_nofwd"}, 32'(n_hazard), 32'(e.hz_nf));
                if (e.chk_vn) check({e.name, ".val_rn"}, val_rn, e.vn);
                if (e.chk_vm) check({e.name, ".val_rm"}, val_rm, e.vm);
            end
        end
    end

    task automatic tick(input exp_t e);
        @(posedge clk);
        sb.push_back(e);
        pushed++;
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        wb_en_in = 0; wb_dest = 0; wb_value = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 0;
        mem_wb_en = 0; mem_dest = 0; freeze = 0; flush = 0;
        sr = 4'b0000; pc = 32'h0;
    endtask

    localparam logic [31:0] ADD_R1_R2_R3 = 32'hE0821003;
    localparam logic [31:0] ADDEQ        = 32'h00821003;
    localparam logic [31:0] ADD_NV       = 32'hF0821003;
    localparam logic [31:0] MOV_R1_R3    = 32'hE1A21003;
    localparam logic [31:0] BL_INSN      = 32'hEB000010;
    localparam logic [31:0] ADD_R0_R14   = 32'hE08E0000;
    localparam logic [31:0] MOV_R5_R4    = 32'hE1A05004;

    localparam logic [8:0] C_NONE = 9'b0;
    localparam logic [8:0] C_ADD  = {5'b10000, 4'b0010};
    localparam logic [8:0] C_MOV  = {5'b10000, 4'b0001};
    localparam logic [8:0] C_B    = {5'b00010, 4'b0000};

    initial begin
        int budget;
        rst = 1'b1;
        instruction = 32'h0;
        idle();
        @(negedge clk); #2;
        tick(mk("reset", C_NONE, 0, 0, 0, 1, 32'h0, 1, 32'h0, 1));
        rst = 1'b0;

        instruction = ADD_R1_R2_R3;
        tick(mk("add_basic", C_ADD, 1, 0, 0, 1, 32'h2, 1, 32'h3, 1));

        wb_en_in = 1; wb_dest = 2; wb_value = 32'h55;
        tick(mk("wb_bypass", C_ADD, 1, 0, 0, 0, 32'h55, 1, 32'h3, 1));
        idle();
        tick(mk("wb_written", C_ADD, 1, 0, 0, 0, 32'h55, 1, 32'h3, 1));

        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 2;
        tick(mk("load_use", C_NONE, 1, 1, 1, 1, 32'h55, 1, 32'h0, 0));
        exe_mem_r_en = 0;
        tick(mk("exe_alu_raw", C_ADD, 1, 0, 1, 1, 32'h0, 0, 32'h0, 0));
        idle();
        mem_wb_en = 1; mem_dest = 2;
        tick(mk("mem_raw", C_ADD, 1, 0, 1, 1, 32'h0, 0, 32'h0, 0));
        mem_dest = 3;
        tick(mk("mem_raw_rm", C_ADD, 1, 0, 1, 1, 32'h0, 0, 32'h0, 0));
        instruction = MOV_R1_R3; mem_dest = 2;
        tick(mk("mov_unused_rn", C_MOV, 1, 0, 0, 1, 32'h0, 0, 32'h3, 1));
        idle();

        instruction = ADDEQ; sr = 4'b0000;
        tick(mk("addeq_z0", C_NONE, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        sr = 4'b0100;
        tick(mk("addeq_z1", C_ADD, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        instruction = ADD_NV; sr = 4'b1111;
        tick(mk("cond_never", C_NONE, 1, 0, 0, 0, 32'h55, 1, 32'h0, 0));
        idle();

        instruction = BL_INSN; pc = 32'h40;
        tick(mk("bl", C_B, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        idle();
        instruction = ADD_R0_R14;
        tick(mk("link_r14", C_ADD, 0, 0, 0, 0, 32'h40, 1, 32'h0, 1));
        instruction = BL_INSN; pc = 32'h80;
        wb_en_in = 1; wb_dest = 14; wb_value = 32'h99;
        tick(mk("bl_vs_wb", C_B, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
        idle();
        instruction = ADD_R0_R14;
        tick(mk("link_wins", C_ADD, 0, 0, 0, 0, 32'h80, 1, 32'h0, 1));

        instruction = ADD_R1_R2_R3;
        tick(mk("pre_freeze", C_ADD, 1, 0, 0, 0, 32'h55, 1, 32'h3, 1));
        instruction = MOV_R5_R4; freeze = 1;
        tick(mk("freeze_hold", C_ADD, 1, 0, 0, 0, 32'h55, 1, 32'h3, 1));
        flush = 1;
        tick(mk("flush_freeze", C_NONE, 0, 0, 0, 0, 32'h0, 1, 32'h0, 1));
        idle();

        instruction = ADD_R1_R2_R3;
        tick(mk("pre_reset", C_ADD, 1, 0, 0, 0, 32'h55, 1, 32'h3, 1));
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.ctrl", 32'({wb_en, mem_r_en, mem_w_en, b, s, exe_cmd}), 32'h0);
        check("async_rst.dest", 32'(dest), 32'h0);
        check("async_rst.val_rn", val_rn, 32'h0);
        @(negedge clk); #2;
        rst = 1'b0;
        tick(mk("rf_after_reset", C_ADD, 1, 0, 0, 0, 32'h2, 1, 32'h3, 1));

        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        #1;
        check("scoreboard_drained", 32'(popped), 32'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised decode stage for the 5-stage ARM-subset pipeline.
- Contains the decoder, condition check, an internal 15-entry register file with write-back bypass, and load-use/RAW hazard detection. The hazard check is forwarding-aware.
- Contains an internal ID/EX pipeline register with freeze and flush.
- Sits between IF/ID and EXE. All EXE-facing outputs are registered.

Parameters:
- DATA_W, 32, datapath and register width.
- FORWARD_EN, 1. 1: stall only on load-use against EXE. 0: stall on any RAW against EXE or MEM.
- LINK_EN, 1. 1: BL writes the link value into r14.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instruction  in  32  from IF/ID
- pc  in  DATA_W  IF/ID pc (already +4)
- sr  in  4  status {N,Z,C,V}
- wb_en_in  in  1  write-back enable
- wb_dest  in  4  write-back register
- wb_value  in  DATA_W  write-back data
- exe_wb_en, exe_mem_r_en  in  1 each  from the instruction in EXE
- exe_dest  in  4  EXE destination
- mem_wb_en  in  1  from the instruction in MEM
- mem_dest  in  4  MEM destination
- freeze  in  1  hold the ID/EX register
- flush  in  1  branch taken; bubble the ID/EX register
- hazard  out  1  combinational; IF and IF/ID hold when 1
- wb_en, mem_r_en, mem_w_en, b, s  out  1 each  registered controls
- exe_cmd  out  4  registered
- val_rn, val_rm, pc_out  out  DATA_W  registered
- imm  out  1  registered
- shift_operand  out  12  registered
- signed_imm_24  out  24  registered
- dest, src1_out, src2_out  out  4 each  registered (src1_out/src2_out feed forwarding)

Behaviour:

Decode fields:
- mode = instr[27:26]; op = instr[24:21]; S = instr[20]; imm = instr[25].

exe_cmd mapping (mode 00):
- MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011.
- SUB 0010→0100, SBC 0110→0101, AND 0000→0110, ORR 1100→0111.
- EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
- Other opcodes → all controls 0 (NOP).
- Mode 01 (LDR when S=1, STR when S=0) → exe_cmd 0010.

Control outputs:
- wb_en = 1 for mode 00 except CMP/TST, and for LDR.
- mem_r_en = 1 for LDR; mem_w_en = 1 for STR.
- b = 1 for mode 10.
- s = S for mode 00, else 0.

Condition check (cond = instr[31:28], standard ARM codes):
- 0000 EQ … 1101 LE evaluated on sr.
- 1110 AL = true; 1111 = false.
- Failed condition → all controls 0; data fields still loaded.

Source registers:
- src1 = instr[19:16]. Used for mode 00 except MOV/MVN, and for mode 01.
- src2 = instr[15:12] for STR. Otherwise instr[3:0] when mode 00, imm=0, instr[4]=0; otherwise unused.
- Unused sources never raise a hazard.

Register file:
- r0..r14, DATA_W each. Reset value of ri = i.
- Reading index 15 returns pc.
- Write on the posedge when wb_en_in=1 and wb_dest≠15.
- Same-cycle bypass: a read with index == wb_dest and wb_en_in=1 returns wb_value.

Link (LINK_EN=1):
- Applies to a condition-passing BL (mode 10, instr[24]=1) that is actually loaded (not frozen, flushed or hazarded).
- Writes pc into r14 at the posedge.
- If a WB write targets r14 in the same cycle, the link write wins.

Hazard (combinational):
- FORWARD_EN=1: hazard = exe_mem_r_en & exe_wb_en & used-src == exe_dest.
- FORWARD_EN=0: hazard = (exe_wb_en & used-src == exe_dest) | (mem_wb_en & used-src == mem_dest).

ID/EX register update, priority order:
1. rst asserted: all outputs 0 immediately (async).
2. flush: bubble (all outputs 0).
3. freeze: hold all outputs.
4. hazard: controls 0, data loaded.
5. Otherwise: load.

Timing and reset:
- Latency: 1 cycle from instruction to outputs.
- hazard is independent of freeze.
- Reset mid-operation discards the register contents and restores the register-file reset values.

Test Plan:
- Reset, then ADD r1,r2,r3 (AL, imm=0) → next cycle exe_cmd=0010, wb_en=1, val_rn=2, val_rm=3, dest=1.
- wb_en_in=1, wb_dest=2, wb_value=0x55, with ADD r1,r2,r3 in the same cycle → val_rn=0x55 next cycle; r2 reads 0x55 afterwards.
- FORWARD_EN=1, exe LDR to r2 (exe_mem_r_en=1, exe_dest=2), ID uses r2 → hazard=1, next-cycle controls 0. With exe_mem_r_en=0 → hazard=0. With FORWARD_EN=0 and mem_dest=2 → hazard=1.
- ADDEQ with sr Z=0 → controls 0 and dest loaded. With Z=1 → wb_en=1. cond 1111 → controls 0.
- BL at pc=0x40, AL → b=1 next cycle, r14=0x40. With simultaneous wb to r14=0x99 → r14=0x40.
- freeze with a new instruction → outputs unchanged. flush and freeze together → all 0. Async rst mid-cycle → outputs 0 before the next edge.
